// File: rtl/i2c_target_rx.sv
// i2c_target_rx: I2C target-side byte receiver.
// Synchronises SCL/SDA, detects START/STOP, shifts bytes in MSB-first and
// delivers each completed data byte as a one-cycle rx_valid pulse. When
// ADDR_CHECK=1 the first byte after START is address+R/W and only a write to
// TARGET_ADDR lets the following bytes through.
// Optional macro I2C_TARGET_ACK_EN adds a 9th-clock ACK (SDA pulled low).
// Without it SDA is never driven.
// Ports:
//   clk, reset   - system clock, synchronous active-high reset
//   SCL          - I2C clock from the master
//   SDA          - I2C data (open drain: this block drives 0 or z only)
//   rx_data      - last received data byte
//   rx_valid     - one-cycle pulse when rx_data is updated
//   addr_match   - current transfer is a write addressed to this target
//   busy         - high from START until STOP
//   start_det    - one-cycle pulse on START / repeated START
//   stop_det     - one-cycle pulse on STOP
module i2c_target_rx #(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter bit         ADDR_CHECK  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SCL,
  inout  wire        SDA,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       addr_match,
  output logic       busy,
  output logic       start_det,
  output logic       stop_det
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 4;

`ifdef I2C_TARGET_ACK_EN
  typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_IGNORE, ST_ACK} state_t;
  localparam state_t ST_AFTER_BYTE = ST_ACK;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_IGNORE} state_t;
  localparam state_t ST_AFTER_BYTE = ST_DATA;
`endif

  // Two-flop synchronisers plus one delay flop; reset to the idle bus level
  logic scl_q1, scl_s, scl_d;
  logic sda_q1, sda_s, sda_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_q1 <= 1'b1;
      scl_s  <= 1'b1;
      scl_d  <= 1'b1;
      sda_q1 <= 1'b1;
      sda_s  <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_q1 <= SCL;
      scl_s  <= scl_q1;
      scl_d  <= scl_s;
      sda_q1 <= SDA;
      sda_s  <= sda_q1;
      sda_d  <= sda_s;
    end
  end

  // Bus events from the synchronised samples
  logic scl_rise_c, start_c, stop_c;
  assign scl_rise_c = scl_s & ~scl_d;
  assign start_c    = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_c     = scl_s & scl_d & ~sda_d & sda_s;

`ifdef I2C_TARGET_ACK_EN
  logic scl_fall_c;
  assign scl_fall_c = ~scl_s & scl_d;
`endif

  state_t               state_q, state_n;
  logic [BYTE_W-1:0]    shift_q, shift_n;
  logic [CNT_W-1:0]     cnt_q, cnt_n;
  logic [BYTE_W-1:0]    rx_data_n;
  logic                 rx_valid_n, addr_match_n, busy_n, start_det_n, stop_det_n;
  logic [BYTE_W-1:0]    byte_c;
  logic                 byte_done_c;
`ifdef I2C_TARGET_ACK_EN
  logic                 sda_oe_q, sda_oe_n;
`endif

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      addr_match <= 1'b0;
      busy       <= 1'b0;
      start_det  <= 1'b0;
      stop_det   <= 1'b0;
`ifdef I2C_TARGET_ACK_EN
      sda_oe_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_n;
      shift_q    <= shift_n;
      cnt_q      <= cnt_n;
      rx_data    <= rx_data_n;
      rx_valid   <= rx_valid_n;
      addr_match <= addr_match_n;
      busy       <= busy_n;
      start_det  <= start_det_n;
      stop_det   <= stop_det_n;
`ifdef I2C_TARGET_ACK_EN
      sda_oe_q   <= sda_oe_n;
`endif
    end
  end

  // Next-state and output logic; START beats STOP beats bit events
  always_comb begin
    state_n      = state_q;
    shift_n      = shift_q;
    cnt_n        = cnt_q;
    rx_data_n    = rx_data;
    rx_valid_n   = 1'b0;
    addr_match_n = addr_match;
    busy_n       = busy;
    start_det_n  = 1'b0;
    stop_det_n   = 1'b0;
`ifdef I2C_TARGET_ACK_EN
    sda_oe_n     = sda_oe_q;
`endif
    byte_c       = {shift_q[BYTE_W-2:0], sda_s};
    byte_done_c  = (cnt_q == CNT_W'(BYTE_W - 1));

    if (start_c) begin
      state_n      = ADDR_CHECK ? ST_ADDR : ST_DATA;
      cnt_n        = '0;
      addr_match_n = 1'b0;
      busy_n       = 1'b1;
      start_det_n  = 1'b1;
`ifdef I2C_TARGET_ACK_EN
      sda_oe_n     = 1'b0;
`endif
    end else if (stop_c) begin
      state_n      = ST_IDLE;
      cnt_n        = '0;
      addr_match_n = 1'b0;
      busy_n       = 1'b0;
      stop_det_n   = 1'b1;
`ifdef I2C_TARGET_ACK_EN
      sda_oe_n     = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (scl_rise_c) begin
            shift_n = byte_c;
            if (byte_done_c) begin
              cnt_n = '0;
              // Only a write to our address opens the data phase
              if (byte_c[BYTE_W-1:1] == TARGET_ADDR && !byte_c[0]) begin
                addr_match_n = 1'b1;
                state_n      = ST_AFTER_BYTE;
              end else begin
                state_n = ST_IGNORE;
              end
            end else begin
              cnt_n = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_DATA: begin
          if (scl_rise_c) begin
            shift_n = byte_c;
            if (byte_done_c) begin
              cnt_n      = '0;
              rx_data_n  = byte_c;
              rx_valid_n = 1'b1;
              state_n    = ST_AFTER_BYTE;
            end else begin
              cnt_n = cnt_q + CNT_W'(1);
            end
          end
        end
`ifdef I2C_TARGET_ACK_EN
        // First fall after bit 8 pulls SDA low; the fall after the 9th
        // clock releases it and resumes data capture
        ST_ACK: begin
          if (scl_fall_c) begin
            if (!sda_oe_q) begin
              sda_oe_n = 1'b1;
            end else begin
              sda_oe_n = 1'b0;
              cnt_n    = '0;
              state_n  = ST_DATA;
            end
          end
        end
`endif
        default: begin
          state_n = state_q;
        end
      endcase
    end
  end

  // Open-drain data line
`ifdef I2C_TARGET_ACK_EN
  assign SDA = sda_oe_q ? 1'b0 : 1'bz;
`else
  assign SDA = 1'bz;
`endif

endmodule
